// File: rtl/interact_pkg.sv
// Shared types and default timing constants for the core reset sequencer.
package interact_pkg;

    // Sequencer states; encodings are exposed over the bridge through state_o.
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StQuiesce  = 3'd1,
        StHold     = 3'd2,
        StWaitLock = 3'd3,
        StRelease  = 3'd4
    } rst_state_t;

    localparam int unsigned RST_HOLD_DEF = 20000;
    localparam int unsigned RST_QTO_DEF  = 4096;
    localparam int unsigned RST_LOCK_DEF = 256;

endpackage

// File: rtl/interact_stable_cnt.sv
// Consecutive-high filter: hit asserts in the cycle where `in` has been high for TARGET
// consecutive enabled cycles. Any low cycle or a clr restarts the count from zero.
module interact_stable_cnt #(
    parameter int unsigned TARGET = 256,
    parameter int unsigned WIDTH  = $clog2(TARGET + 1)
) (
    input  logic clk_74a,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic in,
    output logic hit
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TARGET - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign hit = en & in & (cnt_q == LAST);

    // Next count: restart on clr, on a low sample, or after a hit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (!in || hit) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interact_reset_seq.sv
// Core reset sequencer in the clk_74a domain. Collects bridge reset requests, asks the
// memory controller to quiesce, holds core_reset for HOLD_CYCLES and releases once the
// core PLL has been locked for LOCK_CYCLES consecutive cycles.
// Optional build macro INTERACT_RST_STATS_EN adds saturating rst_count / to_count outputs.
module interact_reset_seq
    import interact_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES     = RST_HOLD_DEF,
    parameter int unsigned QUIESCE_TIMEOUT = RST_QTO_DEF,
    parameter int unsigned LOCK_CYCLES     = RST_LOCK_DEF
) (
    input  logic       clk_74a,
    input  logic       reset,
    input  logic       req_cmd,
    input  logic       req_svc,
    input  logic       req_dip,
    input  logic       pll_locked,
    input  logic       quiesce_ack,
    output logic       quiesce_req,
    output logic       core_reset,
    output logic       busy,
    output logic       done,
    output logic       timeout_flag,
    output logic [2:0] state_o
`ifdef INTERACT_RST_STATS_EN
    ,
    output logic [15:0] rst_count,
    output logic [7:0]  to_count
`endif
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned QW = $clog2(QUIESCE_TIMEOUT + 1);
    localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [QW-1:0] Q_LAST = QW'(QUIESCE_TIMEOUT - 1);

    rst_state_t    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [QW-1:0] qtim_q, qtim_d;
    logic          tf_q, tf_d;
    logic          core_reset_q, core_reset_d;
    logic          quiesce_req_q, quiesce_req_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic any_req;
    logic qto_evt;
    logic lock_en;
    logic lock_clr;
    logic lock_hit;

    assign any_req  = req_cmd | req_svc | req_dip;
    assign qto_evt  = (state_q == StQuiesce) && !quiesce_ack && (qtim_q == Q_LAST);
    assign lock_en  = (state_q == StWaitLock);
    // A request in WAIT_LOCK sends us back to HOLD, so the lock count must restart too.
    assign lock_clr = (state_q != StWaitLock) | any_req;

    interact_stable_cnt #(
        .TARGET (LOCK_CYCLES),
        .WIDTH  (LW)
    ) u_lock_cnt (
        .clk_74a (clk_74a),
        .reset   (reset),
        .en      (lock_en),
        .clr     (lock_clr),
        .in      (pll_locked),
        .hit     (lock_hit)
    );

    // Next-state, counters and sticky timeout flag.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        qtim_d     = qtim_q;
        tf_d       = tf_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StQuiesce;
                    qtim_d  = '0;
                    tf_d    = 1'b0;
                end else if (!pll_locked) begin
                    // Loss-of-lock recovery: straight into HOLD, no quiesce handshake.
                    state_d    = StHold;
                    hold_cnt_d = '0;
                end
            end
            StQuiesce: begin
                // Requests here are absorbed; ack wins over a simultaneous timeout.
                if (quiesce_ack) begin
                    state_d    = StHold;
                    hold_cnt_d = '0;
                end else if (qto_evt) begin
                    state_d    = StHold;
                    hold_cnt_d = '0;
                    tf_d       = 1'b1;
                end else begin
                    qtim_d = qtim_q + 1'b1;
                end
            end
            StHold: begin
                if (any_req) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == H_LAST) begin
                    state_d = StWaitLock;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StWaitLock: begin
                if (any_req) begin
                    state_d    = StHold;
                    hold_cnt_d = '0;
                end else if (lock_hit) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                // A request landing on the release cycle starts a new sequence directly.
                if (any_req) begin
                    state_d = StQuiesce;
                    qtim_d  = '0;
                    tf_d    = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d    = StHold;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Registered output values derived from the next state.
    always_comb begin
        core_reset_d  = (state_d == StHold) || (state_d == StWaitLock);
        busy_d        = (state_d != StIdle);
        done_d        = (state_d == StRelease);
        quiesce_req_d = 1'b0;
        unique case (state_d)
            StQuiesce:          quiesce_req_d = 1'b1;
            // Held rather than forced: the power-up and loss-of-lock paths never quiesce.
            StHold, StWaitLock: quiesce_req_d = quiesce_req_q;
            default:            quiesce_req_d = 1'b0;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state_q       <= StHold;
            hold_cnt_q    <= '0;
            qtim_q        <= '0;
            tf_q          <= 1'b0;
            core_reset_q  <= 1'b1;
            quiesce_req_q <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            qtim_q        <= qtim_d;
            tf_q          <= tf_d;
            core_reset_q  <= core_reset_d;
            quiesce_req_q <= quiesce_req_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign state_o      = state_q;
    assign core_reset   = core_reset_q;
    assign quiesce_req  = quiesce_req_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout_flag = tf_q;

`ifdef INTERACT_RST_STATS_EN
    logic [15:0] rst_count_q;
    logic [7:0]  to_count_q;

    // Saturating sequence and timeout counters, cleared only by block reset.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            rst_count_q <= '0;
            to_count_q  <= '0;
        end else begin
            if (done_d && (rst_count_q != 16'hFFFF)) begin
                rst_count_q <= rst_count_q + 1'b1;
            end
            if (qto_evt && (to_count_q != 8'hFF)) begin
                to_count_q <= to_count_q + 1'b1;
            end
        end
    end

    assign rst_count = rst_count_q;
    assign to_count  = to_count_q;
`endif

endmodule
